// File: rtl/vlsu_pkg.sv
// Shared VLSU meta-path types and the default sizing of the meta broadcast fork.
package vlsu_pkg;

    typedef struct packed {
        logic [2:0] eew;
        logic [4:0] vreg;
        logic [7:0] vl;
    } meta_glb_t;

    localparam int unsigned MetaNumOut = 2;
    localparam int unsigned MetaDepth  = 2;

endpackage

// File: rtl/meta_bcast_fifo.sv
// Single-consumer FIFO of the meta broadcast fork; DEPTH need not be a power of two.
module meta_bcast_fifo
    import vlsu_pkg::*;
#(
    parameter type         meta_glb_t = logic,
    parameter int unsigned DEPTH      = MetaDepth
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  meta_glb_t                  data_i,
    input  logic                       pop_i,
    output meta_glb_t                  data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o
);

    localparam int unsigned     CntW    = $clog2(DEPTH + 1);
    localparam int unsigned     PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    meta_glb_t       mem [DEPTH];
    logic [PtrW-1:0] wptr_q;
    logic [PtrW-1:0] rptr_q;
    logic [CntW-1:0] cnt_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    assign data_o  = mem[rptr_q];

    // Flush overrides any push or pop arriving in the same cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr_q] <= data_i;
        end
    end

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= FullCnt);

    a_head_hold: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
        (!empty_o && !pop_i) |=> (!empty_o && $stable(data_o)));

endmodule

// File: rtl/meta_bcast_fork.sv
// Buffered N-way broadcast of VLSU global meta info; each consumer drains its own FIFO.
module meta_bcast_fork
    import vlsu_pkg::*;
#(
    parameter type         meta_glb_t = logic,
    parameter int unsigned NUM_OUT    = MetaNumOut,
    parameter int unsigned DEPTH      = MetaDepth
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    flush_i,
    input  logic                                    meta_valid_i,
    output logic                                    meta_ready_o,
    input  meta_glb_t                               meta_i,
    input  logic [NUM_OUT-1:0]                      dest_mask_i,
    output logic [NUM_OUT-1:0]                      out_valid_o,
    input  logic [NUM_OUT-1:0]                      out_ready_i,
    output meta_glb_t [NUM_OUT-1:0]                 out_o,
    output logic [NUM_OUT-1:0][$clog2(DEPTH+1)-1:0] out_cnt_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [NUM_OUT-1:0]           full;
    logic [NUM_OUT-1:0]           empty;
    logic [NUM_OUT-1:0]           push;
    logic [NUM_OUT-1:0]           pop;
    logic [NUM_OUT-1:0][CntW-1:0] cnt;
    logic                         fire;

    // Only targeted outputs can block; a pop in this cycle gives no credit.
    always_comb begin
        meta_ready_o = 1'b1;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (dest_mask_i[k] && full[k]) begin
                meta_ready_o = 1'b0;
            end
        end
    end

    assign fire        = meta_valid_i && meta_ready_o;
    assign push        = {NUM_OUT{fire}} & dest_mask_i;
    assign out_valid_o = ~empty;
    assign pop         = out_valid_o & out_ready_i;
    assign out_cnt_o   = cnt;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        meta_bcast_fifo #(
            .meta_glb_t (meta_glb_t),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .push_i  (push[k]),
            .data_i  (meta_i),
            .pop_i   (pop[k]),
            .data_o  (out_o[k]),
            .full_o  (full[k]),
            .empty_o (empty[k]),
            .cnt_o   (cnt[k])
        );
    end

    a_in_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (meta_valid_i && !meta_ready_o) |=>
            (!meta_valid_i || ($stable(meta_i) && $stable(dest_mask_i))));

endmodule

// File: tb/tb_meta_bcast_fork.sv
// Scoreboard bench for meta_bcast_fork: a 2-output/depth-2 instance and a 1-output/depth-3 instance.
module tb_meta_bcast_fork;
    import vlsu_pkg::*;

    logic clk;
    logic rst_n;

    logic                  flush2, valid2, ready2;
    meta_glb_t             meta2;
    logic [1:0]            mask2, ovalid2, ordy2;
    meta_glb_t [1:0]       out2;
    logic [1:0][1:0]       cnt2;

    logic                  flush3, valid3, ready3;
    meta_glb_t             meta3;
    logic [0:0]            mask3, ovalid3, ordy3;
    meta_glb_t [0:0]       out3;
    logic [0:0][1:0]       cnt3;

    meta_glb_t exp0[$];
    meta_glb_t exp1[$];
    meta_glb_t exp3[$];

    int total = 0;
    int bad   = 0;
    int w;

    meta_bcast_fork #(.meta_glb_t(meta_glb_t), .NUM_OUT(2), .DEPTH(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush2),
        .meta_valid_i(valid2), .meta_ready_o(ready2), .meta_i(meta2),
        .dest_mask_i(mask2), .out_valid_o(ovalid2), .out_ready_i(ordy2),
        .out_o(out2), .out_cnt_o(cnt2)
    );

    meta_bcast_fork #(.meta_glb_t(meta_glb_t), .NUM_OUT(1), .DEPTH(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush3),
        .meta_valid_i(valid3), .meta_ready_o(ready3), .meta_i(meta3),
        .dest_mask_i(mask3), .out_valid_o(ovalid3), .out_ready_i(ordy3),
        .out_o(out3), .out_cnt_o(cnt3)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s got=timeout want=ready", name);
    endtask

    // Drive one input beat on the 2-output fork and record where it must appear.
    task automatic applyStimulus(input meta_glb_t m, input logic [1:0] mask, output int waited);
        meta2  = m;
        mask2  = mask;
        valid2 = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!ready2 && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!ready2) begin
            timeoutFail("in2_ready");
        end else begin
            if (mask[0]) exp0.push_back(m);
            if (mask[1]) exp1.push_back(m);
        end
        @(posedge clk);
        #1;
        valid2 = 1'b0;
    endtask

    task automatic push3(input meta_glb_t m, output int waited);
        meta3  = m;
        mask3  = 1'b1;
        valid3 = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!ready3 && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!ready3) timeoutFail("in3_ready");
        else exp3.push_back(m);
        @(posedge clk);
        #1;
        valid3 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake on an output pops the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && !flush2) begin
            if (ovalid2[0] && ordy2[0]) begin
                if (exp0.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL out0_unexpected got=%h want=none", out2[0]);
                end else checkOutput("out0_data", out2[0], exp0.pop_front());
            end
            if (ovalid2[1] && ordy2[1]) begin
                if (exp1.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL out1_unexpected got=%h want=none", out2[1]);
                end else checkOutput("out1_data", out2[1], exp1.pop_front());
            end
        end
        if (rst_n && !flush3 && ovalid3[0] && ordy3[0]) begin
            if (exp3.size() == 0) begin
                total++; bad++;
                $display("[TB] FAIL out3_unexpected got=%h want=none", out3[0]);
            end else checkOutput("out3_data", out3[0], exp3.pop_front());
        end
    end

    initial begin
        clk = 0; rst_n = 0;
        flush2 = 0; valid2 = 0; meta2 = '0; mask2 = 2'b11; ordy2 = 2'b00;
        flush3 = 0; valid3 = 0; meta3 = '0; mask3 = 1'b1;  ordy3 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        checkOutput("rst_ready", ready2, 1);
        checkOutput("rst_valid", ovalid2, 0);
        checkOutput("rst_cnt", cnt2, 0);
        checkOutput("rst_valid3", ovalid3, 0);
        @(posedge clk); #1;

        $display("[TB] broadcast in order, both ready");
        ordy2 = 2'b11;
        applyStimulus(16'hA001, 2'b11, w);
        checkOutput("t1_wait_a", w, 0);
        @(negedge clk);
        checkOutput("t1_latency_valid", ovalid2, 2'b11);
        @(posedge clk); #1;
        applyStimulus(16'hB002, 2'b11, w);
        checkOutput("t1_wait_b", w, 0);
        applyStimulus(16'hC003, 2'b11, w);
        checkOutput("t1_wait_c", w, 0);
        idle(3);
        checkOutput("t1_drained", cnt2, 0);

        $display("[TB] slow output1 backpressure");
        ordy2 = 2'b01;
        applyStimulus(16'hD004, 2'b11, w);
        applyStimulus(16'hE005, 2'b11, w);
        meta2 = 16'hF006; mask2 = 2'b11; valid2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t2_stall_ready", ready2, 0);
            checkOutput("t2_stall_cnt1", cnt2[1], 2);
            @(posedge clk); #1;
        end
        ordy2 = 2'b11;
        @(negedge clk);
        checkOutput("t2_no_pop_credit", ready2, 0);
        @(posedge clk); #1;
        applyStimulus(16'hF006, 2'b11, w);
        checkOutput("t2_accept_next", w, 0);
        idle(3);
        checkOutput("t2_drained", cnt2, 0);

        $display("[TB] output1 full, mask selects output0 only");
        ordy2 = 2'b01;
        applyStimulus(16'h1111, 2'b11, w);
        applyStimulus(16'h2222, 2'b11, w);
        applyStimulus(16'h3333, 2'b01, w);
        checkOutput("t3_wait", w, 0);
        checkOutput("t3_cnt1_full", cnt2[1], 2);
        checkOutput("t3_cnt0", cnt2[0], 1);
        ordy2 = 2'b11;
        idle(4);
        checkOutput("t3_drained", cnt2, 0);

        $display("[TB] empty destination mask");
        ordy2 = 2'b00;
        applyStimulus(16'h4444, 2'b00, w);
        checkOutput("t4_wait", w, 0);
        @(negedge clk);
        checkOutput("t4_valid", ovalid2, 0);
        checkOutput("t4_cnt", cnt2, 0);
        @(posedge clk); #1;

        $display("[TB] depth-3 wrap with concurrent push and pop");
        for (int i = 0; i < 10; i++) begin
            push3(meta_glb_t'(16'h5000 + i), w);
            checkOutput("t5_wait", w, 0);
            checkOutput("t5_cnt", cnt3[0], (i < 2) ? i + 1 : 2);
            if (i == 1) ordy3 = 1'b1;
        end
        idle(3);
        checkOutput("t5_drained", cnt3[0], 0);
        ordy3 = 1'b0;
        for (int i = 0; i < 3; i++) push3(meta_glb_t'(16'h6000 + i), w);
        checkOutput("t5_full_cnt", cnt3[0], 3);
        meta3 = 16'h6003; valid3 = 1'b1;
        @(negedge clk);
        checkOutput("t5_full_ready", ready3, 0);
        @(posedge clk); #1;
        valid3 = 1'b0;
        ordy3 = 1'b1;
        idle(4);
        checkOutput("t5_full_drained", cnt3[0], 0);

        $display("[TB] flush with concurrent fire");
        ordy2 = 2'b00;
        applyStimulus(16'h7001, 2'b11, w);
        applyStimulus(16'h7002, 2'b01, w);
        checkOutput("t6_pre_cnt0", cnt2[0], 2);
        checkOutput("t6_pre_cnt1", cnt2[1], 1);
        meta2 = 16'h7003; mask2 = 2'b10; valid2 = 1'b1; flush2 = 1'b1;
        exp0.delete();
        exp1.delete();
        @(negedge clk);
        checkOutput("t6_flush_ready", ready2, 1);
        @(posedge clk); #1;
        flush2 = 1'b0; valid2 = 1'b0;
        checkOutput("t6_cnt", cnt2, 0);
        checkOutput("t6_valid", ovalid2, 0);
        ordy2 = 2'b11;
        idle(3);
        checkOutput("t6_still_empty", ovalid2, 0);

        $display("[TB] reset mid-stream");
        ordy2 = 2'b00;
        applyStimulus(16'h8001, 2'b11, w);
        applyStimulus(16'h8002, 2'b11, w);
        meta2 = 16'h8003; mask2 = 2'b11; valid2 = 1'b1;
        @(negedge clk);
        checkOutput("t7_full_ready", ready2, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp0.delete();
        exp1.delete();
        exp3.delete();
        idle(2);
        rst_n = 1'b1; valid2 = 1'b0;
        @(negedge clk);
        checkOutput("t7_cnt", cnt2, 0);
        checkOutput("t7_valid", ovalid2, 0);
        checkOutput("t7_ready", ready2, 1);
        @(posedge clk); #1;
        ordy2 = 2'b11;
        idle(3);
        checkOutput("t7_still_empty", ovalid2, 0);

        checkOutput("sb0_empty", exp0.size(), 0);
        checkOutput("sb1_empty", exp1.size(), 0);
        checkOutput("sb3_empty", exp3.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
